// File: rtl/score_digit_renderer.sv
// Multi-digit decimal score renderer: sequential double-dabble conversion of a loaded value
// and a 2-stage per-pixel glyph lookup against the committed digits.
module score_digit_renderer #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned VAL_W      = 14,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 10,
  parameter bit          BLANK_LZ   = 1'b1,
  parameter logic [2:0]  FG_RGB     = 3'b111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [VAL_W-1:0] value,
  input  logic [X_W-1:0]   origin_x,
  input  logic [Y_W-1:0]   origin_y,
  input  logic             pix_valid_in,
  input  logic [X_W-1:0]   px,
  input  logic [Y_W-1:0]   py,
  output logic             pix_valid_out,
  output logic             R,
  output logic             G,
  output logic             B,
  output logic             on
);

  localparam int unsigned DW      = DIGITS * 4;
  localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned IDX_N   = 1 << IDX_W;
  localparam int unsigned CNT_W   = $clog2(VAL_W);
  localparam int unsigned REG_X   = (DIGITS * 8) << SCALE_LOG2;
  localparam int unsigned REG_Y   = 7 << SCALE_LOG2;
  localparam int unsigned SAT_LIM = 10 ** DIGITS;

  // Glyph rows, MSB = column 0; row 7 and codes 10..15 are blank padding
  localparam logic [7:0] FONT [16][8] = '{
    '{8'h7C, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h7C, 8'h00},
    '{8'h78, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7C, 8'h00},
    '{8'h7C, 8'h82, 8'h02, 8'h0C, 8'h30, 8'hC0, 8'hFE, 8'h00},
    '{8'h7C, 8'h82, 8'h02, 8'h3C, 8'h02, 8'h82, 8'h7C, 8'h00},
    '{8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'hFE, 8'h0C, 8'h0C, 8'h00},
    '{8'hFE, 8'h80, 8'hFC, 8'h02, 8'h02, 8'h82, 8'h7C, 8'h00},
    '{8'h7C, 8'h80, 8'hFC, 8'h82, 8'h82, 8'h82, 8'h7C, 8'h00},
    '{8'hFE, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h20, 8'h00},
    '{8'h7C, 8'h82, 8'h82, 8'h7C, 8'h82, 8'h82, 8'h7C, 8'h00},
    '{8'h7C, 8'h82, 8'h82, 8'h7E, 8'h02, 8'h02, 8'h7C, 8'h00},
    '{default: 8'h00},
    '{default: 8'h00},
    '{default: 8'h00},
    '{default: 8'h00},
    '{default: 8'h00},
    '{default: 8'h00}
  };

  typedef enum logic [2:0] {IDLE, SAT_CHK, SAT_FILL, SHIFT, COMMIT} state_t;

  state_t             state, state_nx;
  logic [VAL_W-1:0]   bin;
  logic [DW-1:0]      bcd, bcd_adj, disp, disp_view;
  logic [CNT_W-1:0]   cnt;
  logic               sat_c, last_c;
  logic               accept_c, fill_c, shift_c, commit_c;

  assign sat_c  = 64'(bin) >= 64'(SAT_LIM);
  assign last_c = (cnt == CNT_W'(VAL_W - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state; the saturated path spends one cycle loading all 9s
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (load_valid) state_nx = SAT_CHK;
      SAT_CHK:  state_nx = sat_c ? SAT_FILL : SHIFT;
      SAT_FILL: state_nx = COMMIT;
      SHIFT:    if (last_c) state_nx = COMMIT;
      COMMIT:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Datapath strobes
  always_comb begin
    accept_c = 1'b0;
    fill_c   = 1'b0;
    shift_c  = 1'b0;
    commit_c = 1'b0;
    case (state)
      IDLE:     accept_c = load_valid;
      SAT_FILL: fill_c   = 1'b1;
      SHIFT:    shift_c  = 1'b1;
      COMMIT:   commit_c = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) load_ready <= 1'b1;
    else       load_ready <= (state_nx == IDLE);
  end

  // Double-dabble add-3 correction on every nibble
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin  <= '0;
      bcd  <= '0;
      cnt  <= '0;
      disp <= '0;
    end else begin
      if (accept_c) begin
        bin <= value;
        bcd <= '0;
        cnt <= '0;
      end
      if (fill_c) bcd <= {DIGITS{4'h9}};
      if (shift_c) begin
        bcd <= {bcd_adj[DW-2:0], bin[VAL_W-1]};
        bin <= {bin[VAL_W-2:0], 1'b0};
        cnt <= cnt + CNT_W'(1);
      end
      if (commit_c) disp <= bcd;
    end
  end

  // Render stage 1: origin-relative coordinates and glyph cell decode
  logic [X_W:0]     rx_c;
  logic [Y_W:0]     ry_c;
  logic             in_c;
  logic             s1_valid, s1_in;
  logic [IDX_W-1:0] s1_idx;
  logic [2:0]       s1_col, s1_row;

  always_comb begin
    rx_c = {1'b0, px} - {1'b0, origin_x};
    ry_c = {1'b0, py} - {1'b0, origin_y};
    in_c = !rx_c[X_W] && !ry_c[Y_W] &&
           (32'(rx_c[X_W-1:0]) < REG_X) && (32'(ry_c[Y_W-1:0]) < REG_Y);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_in    <= 1'b0;
      s1_idx   <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
    end else begin
      s1_valid <= pix_valid_in;
      s1_in    <= in_c;
      s1_idx   <= IDX_W'(rx_c[X_W-1:0] >> (SCALE_LOG2 + 3));
      s1_col   <= 3'(rx_c[X_W-1:0] >> SCALE_LOG2);
      s1_row   <= 3'(ry_c[Y_W-1:0] >> SCALE_LOG2);
    end
  end

  // Render stage 2: digit select with leading-zero blanking; committing digits bypass the register
  logic [3:0]       digit_arr [IDX_N];
  logic [IDX_N-1:0] blank_arr;
  logic             zero_run;
  logic [3:0]       code_c;
  logic             on_c;

  always_comb begin
    disp_view = commit_c ? bcd : disp;
    digit_arr = '{default: 4'h0};
    blank_arr = '0;
    zero_run  = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      digit_arr[i] = disp_view[(DIGITS-1-i)*4 +: 4];
      zero_run     = zero_run && (digit_arr[i] == 4'h0);
      blank_arr[i] = BLANK_LZ && (i < int'(DIGITS) - 1) && zero_run;
    end
    code_c = digit_arr[s1_idx];
    on_c   = s1_valid && s1_in && !blank_arr[s1_idx] && FONT[code_c][s1_row][~s1_col];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid_out <= 1'b0;
      on            <= 1'b0;
      R             <= 1'b0;
      G             <= 1'b0;
      B             <= 1'b0;
    end else begin
      pix_valid_out <= s1_valid;
      on            <= on_c;
      R             <= on_c & FG_RGB[2];
      G             <= on_c & FG_RGB[1];
      B             <= on_c & FG_RGB[0];
    end
  end

endmodule

// File: tb/tb_score_digit_renderer.sv
// Bench for score_digit_renderer: directed and random loads/pixel streams checked against
// a decimal arithmetic model of the displayed string (blanking on and off instances).
module tb_score_digit_renderer;

  localparam int DIGITS = 4;
  localparam int SC     = 2;
  localparam int OX     = 100;
  localparam int OY     = 50;

  localparam logic [7:0] TB_FONT [10][7] = '{
    '{8'h7C, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h7C},
    '{8'h78, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7C},
    '{8'h7C, 8'h82, 8'h02, 8'h0C, 8'h30, 8'hC0, 8'hFE},
    '{8'h7C, 8'h82, 8'h02, 8'h3C, 8'h02, 8'h82, 8'h7C},
    '{8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'hFE, 8'h0C, 8'h0C},
    '{8'hFE, 8'h80, 8'hFC, 8'h02, 8'h02, 8'h82, 8'h7C},
    '{8'h7C, 8'h80, 8'hFC, 8'h82, 8'h82, 8'h82, 8'h7C},
    '{8'hFE, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h20},
    '{8'h7C, 8'h82, 8'h82, 8'h7C, 8'h82, 8'h82, 8'h7C},
    '{8'h7C, 8'h82, 8'h82, 8'h7E, 8'h02, 8'h02, 8'h7C}
  };

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [13:0] value;
  logic [9:0]  origin_x, origin_y, px, py;
  logic        pix_valid_in;
  logic        load_ready, pix_valid_out, R, G, B, on;
  logic        load_ready_nb, pix_valid_out_nb, R_nb, G_nb, B_nb, on_nb;

  typedef struct packed {logic v; logic on; logic nb;} exp_t;
  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   disp_m   = 0;

  always #5 clk = ~clk;

  score_digit_renderer u_dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready), .value(value),
    .origin_x(origin_x), .origin_y(origin_y), .pix_valid_in(pix_valid_in), .px(px), .py(py),
    .pix_valid_out(pix_valid_out), .R(R), .G(G), .B(B), .on(on)
  );

  score_digit_renderer #(.BLANK_LZ(1'b0)) u_dut_nb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_nb), .value(value),
    .origin_x(origin_x), .origin_y(origin_y), .pix_valid_in(pix_valid_in), .px(px), .py(py),
    .pix_valid_out(pix_valid_out_nb), .R(R_nb), .G(G_nb), .B(B_nb), .on(on_nb)
  );

  // Reference: decimal digit arithmetic on the displayed integer
  function automatic logic model_on(int x, int y, int d, bit blz);
    int rx = x - OX;
    int ry = y - OY;
    int gx, gy, idx, col, p;
    if (rx < 0 || ry < 0 || rx >= DIGITS * 8 * SC || ry >= 7 * SC) return 1'b0;
    gx  = rx / SC;
    gy  = ry / SC;
    idx = gx / 8;
    col = gx % 8;
    p   = 10 ** (DIGITS - 1 - idx);
    if (blz && idx < DIGITS - 1 && d / p == 0) return 1'b0;
    return TB_FONT[(d / p) % 10][gy][7 - col];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pipeline step at the falling edge: check the query issued two steps ago, then issue a new one
  task automatic step_pix(logic v, int x, int y, int lit_on = -1, int lit_nb = -1);
    exp_t e;
    if (q.size() == 2) begin
      e = q.pop_front();
      chk("pix_valid_out", 32'(pix_valid_out), 32'(e.v));
      chk("on", 32'(on), 32'(e.on));
      chk("rgb", 32'({R, G, B}), e.on ? 32'd7 : 32'd0);
      chk("on_nb", 32'(on_nb), 32'(e.nb));
      chk("pix_valid_out_nb", 32'(pix_valid_out_nb), 32'(e.v));
    end
    pix_valid_in = v;
    px = 10'(x);
    py = 10'(y);
    e.v  = v;
    e.on = v & ((lit_on >= 0) ? lit_on[0] : model_on(x, y, disp_m, 1'b1));
    e.nb = v & ((lit_nb >= 0) ? lit_nb[0] : model_on(x, y, disp_m, 1'b0));
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic flush();
    step_pix(1'b0, 0, 0);
    step_pix(1'b0, 0, 0);
    q.delete();
  endtask

  task automatic scan();
    for (int y = 48; y <= 65; y++)
      for (int x = 98; x <= 166; x++)
        step_pix($urandom_range(0, 3) != 0, x, y);
    flush();
  endtask

  // Load a value, optionally holding load_valid with another value while busy
  task automatic do_load(int v, int busy_val = -1);
    int low = 0;
    chk("ready_before_load", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    value = 14'(v);
    @(negedge clk);
    if (busy_val >= 0) value = 14'(busy_val);
    else load_valid = 1'b0;
    while (load_ready == 1'b0 && low < 40) begin
      low++;
      if (low == 8) load_valid = 1'b0;
      @(negedge clk);
    end
    load_valid = 1'b0;
    chk("ready_low_cycles", 32'(low), (v >= 10000) ? 32'd3 : 32'd16);
    chk("ready_nb_after_load", 32'(load_ready_nb), 32'd1);
    disp_m = (v >= 10000) ? 9999 : v;
    @(negedge clk);
    chk("ready_stays_high", 32'(load_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    load_valid = 1'b0;
    value = '0;
    origin_x = 10'd100;
    origin_y = 10'd50;
    pix_valid_in = 1'b0;
    px = '0;
    py = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_pv", 32'(pix_valid_out), 32'd0);
    chk("rst_on", 32'(on), 32'd0);
    chk("rst_rgb", 32'({R, G, B}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    scan();

    // T1
    do_load(1234);
    step_pix(1'b1, 118, 50, 1, 1);
    flush();
    scan();

    // T2
    do_load(7);
    for (int x = 100; x <= 147; x++) step_pix(1'b1, x, 50, 0);
    step_pix(1'b1, 148, 50, 1, 1);
    flush();
    scan();

    // T3
    do_load(12000);
    step_pix(1'b1, 102, 50, 1, 1);
    flush();
    scan();
    do_load(10000);
    step_pix(1'b1, 102, 50, 1, 1);
    flush();

    // T4
    do_load(5, 42);
    step_pix(1'b1, 148, 50, 1, 1);
    step_pix(1'b1, 102, 50, 0, 1);
    flush();
    scan();

    // T5
    step_pix(1'b1, 99, 50, 0, 0);
    step_pix(1'b1, 164, 50, 0, 0);
    step_pix(1'b1, 100, 49, 0, 0);
    step_pix(1'b1, 100, 64, 0, 0);
    flush();
    do_load(0);
    step_pix(1'b1, 150, 50, 1, 1);
    step_pix(1'b1, 102, 50, 0, 1);
    step_pix(1'b1, 148, 52, 1, 1);
    step_pix(1'b1, 163, 63, 0, 0);
    flush();
    scan();

    // Random loads and pixel streams
    repeat (12) begin
      do_load(int'($urandom_range(0, 16383)));
      repeat (150)
        step_pix($urandom_range(0, 3) != 0, int'($urandom_range(90, 170)), int'($urandom_range(45, 68)));
      flush();
    end

    // T6: reset five cycles into a load
    do_load(9876);
    chk("t6_ready_pre", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    value = 14'd4321;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_busy", 32'(load_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(load_ready), 32'd1);
    chk("t6_rst_pv", 32'(pix_valid_out), 32'd0);
    chk("t6_rst_on", 32'(on), 32'd0);
    chk("t6_rst_rgb", 32'({R, G, B}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q.delete();
    disp_m = 0;
    repeat (20) @(negedge clk);
    chk("t6_idle_ready", 32'(load_ready), 32'd1);
    step_pix(1'b1, 150, 50, 1, 1);
    step_pix(1'b1, 102, 50, 0, 1);
    flush();
    scan();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
